// File: rtl/dly_tap_ctrl.sv
// Delay-line tap walker: accepts a target tap, optionally loads the line, then steps it one tap at a time until read-back matches.
// Optional build macro DLY_TAP_CTRL_SYNC_EN adds a 2-flop synchronizer on dly_tap_val_i (settle grows by 2 cycles).
module dly_tap_ctrl #(
  parameter int TAP_W      = 6,
  parameter int SETTLE_CYC = 4,
  parameter int LOAD_TAP   = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [TAP_W-1:0] req_tap_i,
  input  logic             req_load_i,
  output logic             dly_ld_o,
  output logic             dly_adj_o,
  output logic             dly_incdec_o,
  input  logic [TAP_W-1:0] dly_tap_val_i,
  output logic [TAP_W-1:0] cur_tap_o,
  output logic             done_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int CNT_W = 5;
  localparam logic [TAP_W:0]   STEP_LIM = (TAP_W+1)'(1) << TAP_W;
  localparam logic [TAP_W-1:0] LOAD_V   = LOAD_TAP[TAP_W-1:0];

  logic [TAP_W-1:0] tap_s;

`ifdef DLY_TAP_CTRL_SYNC_EN
  localparam int SETTLE_N = SETTLE_CYC + 2;
  localparam int NOLOAD_N = 2;

  logic [TAP_W-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dly_tap_val_i;
      sync2_q <= sync1_q;
    end
  end

  assign tap_s = sync2_q;
`else
  localparam int SETTLE_N = SETTLE_CYC;
  localparam int NOLOAD_N = 0;

  assign tap_s = dly_tap_val_i;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_STEP, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [TAP_W-1:0] tgt_q, tgt_d;
  logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAP_W:0]   step_cnt_q, step_cnt_d;
  logic             chk_ld_q, chk_ld_d;
  logic             chk_step_q, chk_step_d;
  logic             incdec_q, incdec_d;
  logic [TAP_W:0]   exp_tap;
  logic             ld_q, adj_q, done_q, err_q, busy_q, ready_q;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cur_tap_d  = cur_tap_q;
    cnt_d      = cnt_q;
    step_cnt_d = step_cnt_q;
    chk_ld_d   = chk_ld_q;
    chk_step_d = chk_step_q;
    incdec_d   = incdec_q;
    // Computed one bit wider so a step past either end can never match read-back.
    exp_tap    = incdec_q ? ({1'b0, cur_tap_q} + (TAP_W+1)'(1))
                          : ({1'b0, cur_tap_q} - (TAP_W+1)'(1));

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && ready_q) begin
          tgt_d      = req_tap_i;
          step_cnt_d = '0;
          chk_ld_d   = 1'b0;
          chk_step_d = 1'b0;
          if (req_load_i) begin
            state_d = S_LOAD;
          end else if (NOLOAD_N == 0) begin
            state_d = S_SAMPLE;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = CNT_W'(NOLOAD_N);
          end
        end
      end
      S_LOAD: begin
        chk_ld_d = 1'b1;
        cnt_d    = CNT_W'(SETTLE_N);
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        cur_tap_d  = tap_s;
        chk_ld_d   = 1'b0;
        chk_step_d = 1'b0;
        if (chk_ld_q && (tap_s != LOAD_V)) begin
          state_d = S_ERR;
        end else if (chk_step_q && ({1'b0, tap_s} != exp_tap)) begin
          state_d = S_ERR;
        end else if (tap_s == tgt_q) begin
          state_d = S_DONE;
        end else if (step_cnt_q == STEP_LIM) begin
          state_d = S_ERR;
        end else begin
          state_d  = S_STEP;
          incdec_d = (tgt_q > tap_s);
        end
      end
      S_STEP: begin
        step_cnt_d = step_cnt_q + (TAP_W+1)'(1);
        chk_step_d = 1'b1;
        cnt_d      = CNT_W'(SETTLE_N);
        state_d    = S_SETTLE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      cur_tap_q  <= '0;
      cnt_q      <= '0;
      step_cnt_q <= '0;
      chk_ld_q   <= 1'b0;
      chk_step_q <= 1'b0;
      incdec_q   <= 1'b0;
      ld_q       <= 1'b0;
      adj_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cur_tap_q  <= cur_tap_d;
      cnt_q      <= cnt_d;
      step_cnt_q <= step_cnt_d;
      chk_ld_q   <= chk_ld_d;
      chk_step_q <= chk_step_d;
      incdec_q   <= incdec_d;
      ld_q       <= (state_d == S_LOAD);
      adj_q      <= (state_d == S_STEP);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
      busy_q     <= (state_d != S_IDLE);
      ready_q    <= (state_d == S_IDLE);
    end
  end

  assign req_ready_o  = ready_q;
  assign dly_ld_o     = ld_q;
  assign dly_adj_o    = adj_q;
  assign dly_incdec_o = incdec_q;
  assign cur_tap_o    = cur_tap_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_dly_tap_ctrl.sv
// Bench for dly_tap_ctrl: behavioural delay-line model plus directed and random tap requests.
module tb_dly_tap_ctrl;

  localparam int TAP_W      = 6;
  localparam int SETTLE_CYC = 4;
  localparam int LOAD_TAP   = 0;
  localparam int TAP_MAX    = (1 << TAP_W) - 1;
`ifdef DLY_TAP_CTRL_SYNC_EN
  localparam int SE         = SETTLE_CYC + 2;
  localparam int NOLOAD_LAT = 4;
`else
  localparam int SE         = SETTLE_CYC;
  localparam int NOLOAD_LAT = 2;
`endif
  localparam int STEP_COST = SE + 2;
  localparam int LOAD_LAT  = SE + 3;
  localparam int MAX_CYC   = 40 + (TAP_MAX + 2) * STEP_COST;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [TAP_W-1:0] req_tap = '0;
  logic             req_load = 1'b0;
  logic             dly_ld, dly_adj, dly_incdec;
  logic [TAP_W-1:0] tap_val;
  logic [TAP_W-1:0] cur_tap;
  logic             done, err, busy;

  logic             set_en = 1'b1;
  logic [TAP_W-1:0] set_val = '0;
  logic             stuck = 1'b0;
  logic [TAP_W-1:0] model_tap = '0;

  int n_chk = 0;
  int n_fail = 0;
  int r_ld, r_adj, r_inc, r_dec, r_done_cyc, r_err_cyc, r_min_gap, r_overlap, r_end;

  always #5 clk = ~clk;

  dly_tap_ctrl #(.TAP_W(TAP_W), .SETTLE_CYC(SETTLE_CYC), .LOAD_TAP(LOAD_TAP)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_tap_i(req_tap), .req_load_i(req_load),
    .dly_ld_o(dly_ld), .dly_adj_o(dly_adj), .dly_incdec_o(dly_incdec),
    .dly_tap_val_i(tap_val), .cur_tap_o(cur_tap),
    .done_o(done), .err_o(err), .busy_o(busy)
  );

  // Delay line: loads, saturates at the ends, optionally ignores adjust pulses.
  always @(posedge clk) begin
    if (set_en) model_tap <= set_val;
    else if (dly_ld) model_tap <= TAP_W'(LOAD_TAP);
    else if (dly_adj && !stuck) begin
      if (dly_incdec && model_tap != TAP_W'(TAP_MAX)) model_tap <= model_tap + 1'b1;
      else if (!dly_incdec && model_tap != '0) model_tap <= model_tap - 1'b1;
    end
  end
  assign tap_val = model_tap;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_model(input int v);
    @(negedge clk);
    set_en = 1'b1;
    set_val = TAP_W'(v);
    @(negedge clk);
    set_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Issues one request from a negedge and watches it cycle by cycle (cycle 1 = first cycle after accept).
  task automatic run_req(input int tgt, input int load, input int abort_adj);
    int last_p;
    chk("ready_before_req", int'(req_ready), 1);
    req_valid = 1'b1;
    req_tap = TAP_W'(tgt);
    req_load = load[0];
    @(negedge clk);
    req_valid = 1'b0;
    r_ld = 0; r_adj = 0; r_inc = 0; r_dec = 0;
    r_done_cyc = 0; r_err_cyc = 0; r_min_gap = 100000; r_overlap = 0; r_end = 0;
    last_p = -100000;
    for (int c = 1; c <= MAX_CYC; c++) begin
      if (dly_ld && dly_adj) r_overlap++;
      if (dly_ld || dly_adj) begin
        if (c - last_p < r_min_gap) r_min_gap = c - last_p;
        last_p = c;
      end
      if (dly_ld) r_ld++;
      if (dly_adj) begin
        r_adj++;
        if (dly_incdec) r_inc++; else r_dec++;
      end
      if (done) begin r_done_cyc = c; r_end = 1; break; end
      if (err)  begin r_err_cyc = c;  r_end = 1; break; end
      if (abort_adj > 0 && r_adj == abort_adj) begin rst = 1'b1; r_end = 1; break; end
      @(negedge clk);
    end
    chk("request_finished_in_budget", r_end, 1);
  endtask

  // Reference outcome for a well-behaved line, from the request alone.
  task automatic check_success(input string tag, input int start, input int tgt, input int load);
    int base, steps;
    base  = load ? LOAD_TAP : start;
    steps = (tgt > base) ? tgt - base : base - tgt;
    chk({tag, "_ld_pulses"}, r_ld, load);
    chk({tag, "_adj_pulses"}, r_adj, steps);
    chk({tag, "_inc_pulses"}, r_inc, (tgt > base) ? steps : 0);
    chk({tag, "_dec_pulses"}, r_dec, (tgt > base) ? 0 : steps);
    chk({tag, "_done_cycle"}, r_done_cyc, (load ? LOAD_LAT : NOLOAD_LAT) + steps * STEP_COST);
    chk({tag, "_no_err"}, r_err_cyc, 0);
    chk({tag, "_cur_tap"}, int'(cur_tap), tgt);
    chk({tag, "_busy_at_done"}, int'(busy), 1);
    chk({tag, "_pulse_gap_ok"}, int'(r_min_gap >= SETTLE_CYC + 2), 1);
    chk({tag, "_no_overlap"}, r_overlap, 0);
    @(negedge clk);
    chk({tag, "_ready_after"}, int'(req_ready), 1);
    chk({tag, "_idle_after"}, int'(busy), 0);
  endtask

  initial begin
    int st, tg, ld, quiet;

    // Reset held 3 cycles
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_ld", int'(dly_ld), 0);
    chk("rst_adj", int'(dly_adj), 0);
    chk("rst_incdec", int'(dly_incdec), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cur_tap", int'(cur_tap), 0);
    rst = 1'b0;
    set_en = 1'b0;

    // Load then walk up
    set_model(20);
    run_req(23, 1, 0);
    chk("up_incdec_held", int'(dly_incdec), 1);
    check_success("load_up", 20, 23, 1);

    // Walk down without load
    set_model(10);
    run_req(7, 0, 0);
    check_success("walk_down", 10, 7, 0);

    // Already at target
    set_model(42);
    run_req(42, 0, 0);
    check_success("at_target", 42, 42, 0);

    // Stuck line
    stuck = 1'b1;
    set_model(5);
    run_req(9, 0, 0);
    chk("stuck_adj_pulses", r_adj, 1);
    chk("stuck_err_cycle", r_err_cyc, NOLOAD_LAT + STEP_COST);
    chk("stuck_no_done", r_done_cyc, 0);
    chk("stuck_cur_tap", int'(cur_tap), 5);
    @(negedge clk);
    chk("stuck_ready_after", int'(req_ready), 1);
    stuck = 1'b0;

    // Reset mid-walk
    set_model(0);
    run_req(40, 0, 3);
    chk("abort_adj_seen", r_adj, 3);
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(req_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (dly_adj || dly_ld || busy) quiet++;
    end
    chk("abort_no_more_activity", quiet, 0);
    set_model(3);
    run_req(1, 0, 0);
    check_success("after_abort", 3, 1, 0);

    // Random requests
    for (int i = 0; i < 8; i++) begin
      st = int'($urandom_range(0, TAP_MAX));
      tg = int'($urandom_range(0, TAP_MAX));
      ld = int'($urandom_range(0, 1));
      set_model(st);
      run_req(tg, ld, 0);
      check_success("random", st, tg, ld);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
